// File: rtl/ahb_pkg.sv
// Shared AHB-Lite types and select encodings for the parametrised interconnect.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ahb_pkg;

  localparam int MAX_SLAVES = 16;

  // Data-phase select: 0..MAX_SLAVES-1 name a slave; two extra codes name the
  // built-in default slave and "nothing selected".
  localparam int SEL_W = 5;
  typedef logic [SEL_W-1:0] sel_t;
  localparam sel_t SEL_DEFAULT = 5'd16;
  localparam sel_t SEL_NONE    = 5'd31;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    BUSY   = 2'b01,
    NONSEQ = 2'b10,
    SEQ    = 2'b11
  } htrans_t;

  typedef enum logic {
    OKAY  = 1'b0,
    ERROR = 1'b1
  } hresp_t;

  // NONSEQ and SEQ carry a real transfer; IDLE and BUSY do not.
  function automatic logic is_active(input htrans_t t);
    return (t == NONSEQ) || (t == SEQ);
  endfunction

endpackage

// File: rtl/ahb_interconnect_n_if.sv
// Bus bundle between the AHB-Lite master, the slaves and the interconnect.
// Latency: n/a (wiring only).
// Backpressure: HREADY from the interconnect stalls master and slaves alike.
// Ports: HADDR/HTRANS from master; HREADY/HRESP/HRDATA back to master;
//        HSEL_SIGNALS to slaves; HRDATA/HREADYOUT/HRESP_SIGNALS from slaves.
interface ahb_interconnect_n_if #(
  parameter int NUM_SLAVES = 3
);
  import ahb_pkg::*;

  logic [31:0]              HADDR;
  htrans_t                  HTRANS;
  logic                     HREADY;
  logic                     HRESP;
  logic [31:0]              HRDATA;
  logic [NUM_SLAVES-1:0]    HSEL_SIGNALS;
  logic [32*NUM_SLAVES-1:0] HRDATA_SIGNALS;
  logic [NUM_SLAVES-1:0]    HREADYOUT_SIGNALS;
  logic [NUM_SLAVES-1:0]    HRESP_SIGNALS;

  // Interconnect side: decodes the master request and returns slave responses.
  modport slave (
    input  HADDR, HTRANS, HRDATA_SIGNALS, HREADYOUT_SIGNALS, HRESP_SIGNALS,
    output HREADY, HRESP, HRDATA, HSEL_SIGNALS
  );

  // Master-and-slaves side: drives requests and slave responses.
  modport master (
    output HADDR, HTRANS, HRDATA_SIGNALS, HREADYOUT_SIGNALS, HRESP_SIGNALS,
    input  HREADY, HRESP, HRDATA, HSEL_SIGNALS
  );

endinterface

// File: rtl/ahb_default_slave.sv
// Built-in slave answering unmapped transfers with a two-cycle AHB ERROR.
// Latency: ERROR starts in the data phase right after the accepted address phase.
// Backpressure: drives readyout low for the first error cycle only.
// Ports: HCLK/HRESET; sel (default selected in address phase), hready (bus HREADY);
//        readyout/resp returned through the interconnect mux.
module ahb_default_slave
  import ahb_pkg::*;
(
  input  logic   HCLK,
  input  logic   HRESET,
  input  logic   sel,
  input  logic   hready,
  output logic   readyout,
  output hresp_t resp
);

  typedef enum logic [1:0] {ST_IDLE, ST_ERR1, ST_ERR2} state_t;

  state_t state_q, state_d;

  always_ff @(posedge HCLK) begin
    if (HRESET) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    readyout = 1'b1;
    resp     = OKAY;
    case (state_q)
      ST_IDLE: begin
        if (sel && hready) state_d = ST_ERR1;
      end
      ST_ERR1: begin
        readyout = 1'b0;
        resp     = ERROR;
        state_d  = ST_ERR2;
      end
      ST_ERR2: begin
        resp = ERROR;
        // HREADY is high here, so a new unmapped transfer is accepted now.
        state_d = (sel && hready) ? ST_ERR1 : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: rtl/ahb_interconnect_n.sv
// AHB-Lite interconnect: address decoder, data-phase select, response mux, default slave.
// Latency: zero added; data phase follows the address phase by one cycle.
// Backpressure: HREADY is the selected slave's HREADYOUT (or default-slave ready).
// Ports: HCLK, HRESET (sync, active-high); bus (slave modport of ahb_interconnect_n_if).
module ahb_interconnect_n
  import ahb_pkg::*;
#(
  parameter int                          NUM_SLAVES  = 3,
  parameter logic [NUM_SLAVES-1:0][31:0] BASE_ADDR   = {32'h5000_0000, 32'h4000_0000, 32'h0000_0000},
  parameter logic [NUM_SLAVES-1:0][31:0] ADDR_MASK   = {32'hF000_0000, 32'hF000_0000, 32'hF000_0000},
  parameter bit                          ERR_ON_IDLE = 1'b0
) (
  input  logic                 HCLK,
  input  logic                 HRESET,
  ahb_interconnect_n_if.slave  bus
);

  logic [NUM_SLAVES-1:0] hsel;
  sel_t                  hit_sel;
  logic                  hit_found;
  logic                  def_sel;
  sel_t                  addr_sel;
  sel_t                  sel_q;
  logic                  hready;
  logic                  hresp;
  logic [31:0]           hrdata;
  logic                  ds_readyout;
  hresp_t                ds_resp;

  // Priority decode: the first (lowest-index) hit wins, keeping HSEL one-hot.
  always_comb begin
    hsel      = '0;
    hit_sel   = SEL_NONE;
    hit_found = 1'b0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (!hit_found && ((bus.HADDR & ADDR_MASK[i]) == BASE_ADDR[i])) begin
        hit_found = 1'b1;
        hsel[i]   = 1'b1;
        hit_sel   = sel_t'(i);
      end
    end
  end

  assign def_sel  = !hit_found && (is_active(bus.HTRANS) || ERR_ON_IDLE);
  assign addr_sel = hit_found ? hit_sel : (def_sel ? SEL_DEFAULT : SEL_NONE);

  assign bus.HSEL_SIGNALS = hsel;

  // Address phase is accepted only while HREADY is high.
  always_ff @(posedge HCLK) begin
    if (HRESET)      sel_q <= SEL_NONE;
    else if (hready) sel_q <= addr_sel;
  end

  ahb_default_slave u_default_slave (
    .HCLK     (HCLK),
    .HRESET   (HRESET),
    .sel      (def_sel),
    .hready   (hready),
    .readyout (ds_readyout),
    .resp     (ds_resp)
  );

  // Response mux; only the data-phase owner's HREADYOUT/HRESP are looked at.
  always_comb begin
    hrdata = '0;
    hready = 1'b1;
    hresp  = 1'b0;
    if (sel_q == SEL_DEFAULT) begin
      hready = ds_readyout;
      hresp  = ds_resp;
    end else begin
      for (int i = 0; i < NUM_SLAVES; i++) begin
        if (sel_q == sel_t'(i)) begin
          hrdata = bus.HRDATA_SIGNALS[32*i +: 32];
          hready = bus.HREADYOUT_SIGNALS[i];
          hresp  = bus.HRESP_SIGNALS[i];
        end
      end
    end
  end

  assign bus.HREADY = hready;
  assign bus.HRESP  = hresp;
  assign bus.HRDATA = hrdata;

endmodule

// File: tb/tb_ahb_interconnect_n.sv
// Self-checking bench for ahb_interconnect_n (3-slave map plus a 4-slave overlapping map).
// Latency: expectations are for the outputs visible in the cycle the stimulus is driven.
// Backpressure: slave HREADYOUT patterns are driven from the stimulus table.
module tb_ahb_interconnect_n;
  import ahb_pkg::*;

  typedef struct {
    string       tag;
    logic        rdy;
    logic        resp;
    logic [31:0] data;
    logic [2:0]  hsel3;
    logic [3:0]  hsel4;
  } exp_t;

  logic HCLK;
  logic HRESET;
  int   n_checks;
  int   n_fail;
  exp_t exp_q[$];

  ahb_interconnect_n_if #(.NUM_SLAVES(3)) bus3 ();
  ahb_interconnect_n_if #(.NUM_SLAVES(4)) bus4 ();

  ahb_interconnect_n #(.NUM_SLAVES(3)) dut (
    .HCLK   (HCLK),
    .HRESET (HRESET),
    .bus    (bus3)
  );

  // Slaves 1 and 3 overlap at 0x4xxx_xxxx; slave 1 must win.
  ahb_interconnect_n #(
    .NUM_SLAVES (4),
    .BASE_ADDR  ({32'h4000_0000, 32'h6000_0000, 32'h4000_0000, 32'h0000_0000}),
    .ADDR_MASK  ({32'hF000_0000, 32'hF000_0000, 32'hF000_0000, 32'hF000_0000})
  ) dut4 (
    .HCLK   (HCLK),
    .HRESET (HRESET),
    .bus    (bus4)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One cycle: drive address phase and slave responses, queue what the outputs must show.
  task automatic step(input string tag, input logic rst, input logic [31:0] addr,
                      input htrans_t tr, input logic [2:0] ro, input logic [2:0] rs,
                      input logic e_rdy, input logic e_resp, input logic [31:0] e_data,
                      input logic [2:0] e_hsel3, input logic [3:0] e_hsel4);
    exp_t e;
    @(posedge HCLK);
    #1;
    HRESET                 = rst;
    bus3.HADDR             = addr;
    bus3.HTRANS            = tr;
    bus3.HREADYOUT_SIGNALS = ro;
    bus3.HRESP_SIGNALS     = rs;
    bus4.HADDR             = addr;
    bus4.HTRANS            = tr;
    e.tag   = tag;
    e.rdy   = e_rdy;
    e.resp  = e_resp;
    e.data  = e_data;
    e.hsel3 = e_hsel3;
    e.hsel4 = e_hsel4;
    exp_q.push_back(e);
  endtask

  // Outputs are sampled mid-cycle, away from the rising edge.
  always @(negedge HCLK) begin
    if (exp_q.size() != 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check($sformatf("%s.hready", e.tag), {31'd0, bus3.HREADY}, {31'd0, e.rdy});
      check($sformatf("%s.hresp", e.tag), {31'd0, bus3.HRESP}, {31'd0, e.resp});
      check($sformatf("%s.hrdata", e.tag), bus3.HRDATA, e.data);
      check($sformatf("%s.hsel3", e.tag), {29'd0, bus3.HSEL_SIGNALS}, {29'd0, e.hsel3});
      check($sformatf("%s.hsel4", e.tag), {28'd0, bus4.HSEL_SIGNALS}, {28'd0, e.hsel4});
    end
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    HRESET                 = 1'b1;
    bus3.HADDR             = 32'hF000_0000;
    bus3.HTRANS            = NONSEQ;
    bus3.HRDATA_SIGNALS    = {32'hCAFE_0002, 32'hCAFE_0001, 32'hCAFE_0000};
    bus3.HREADYOUT_SIGNALS = 3'b111;
    bus3.HRESP_SIGNALS     = 3'b000;
    bus4.HADDR             = 32'hF000_0000;
    bus4.HTRANS            = NONSEQ;
    bus4.HRDATA_SIGNALS    = '0;
    bus4.HREADYOUT_SIGNALS = 4'b1111;
    bus4.HRESP_SIGNALS     = 4'b0000;

    //   tag             rst addr           trans   ro      rs      rdy   resp  data           hsel3   hsel4
    step("reset",        1, 32'hF000_0000, NONSEQ, 3'b111, 3'b000, 1'b1, 1'b0, 32'h0,         3'b000, 4'b0000);
    step("t2_addr",      0, 32'h4000_0010, NONSEQ, 3'b111, 3'b000, 1'b1, 1'b0, 32'h0,         3'b010, 4'b0010);
    step("t2_data",      0, 32'h8000_0000, IDLE,   3'b111, 3'b000, 1'b1, 1'b0, 32'hCAFE_0001, 3'b000, 4'b0000);
    step("t3_addr",      0, 32'h0000_0100, NONSEQ, 3'b111, 3'b000, 1'b1, 1'b0, 32'h0,         3'b001, 4'b0001);
    step("t3_wait1",     0, 32'h5000_0000, NONSEQ, 3'b110, 3'b000, 1'b0, 1'b0, 32'hCAFE_0000, 3'b100, 4'b0000);
    step("t3_wait2",     0, 32'h5000_0000, NONSEQ, 3'b110, 3'b000, 1'b0, 1'b0, 32'hCAFE_0000, 3'b100, 4'b0000);
    step("t3_wait3",     0, 32'h5000_0000, NONSEQ, 3'b110, 3'b000, 1'b0, 1'b0, 32'hCAFE_0000, 3'b100, 4'b0000);
    step("t3_done",      0, 32'h5000_0000, NONSEQ, 3'b001, 3'b110, 1'b1, 1'b0, 32'hCAFE_0000, 3'b100, 4'b0000);
    step("t3_s2",        0, 32'h8000_0000, IDLE,   3'b111, 3'b000, 1'b1, 1'b0, 32'hCAFE_0002, 3'b000, 4'b0000);
    step("t4_addr",      0, 32'hF000_0000, NONSEQ, 3'b111, 3'b000, 1'b1, 1'b0, 32'h0,         3'b000, 4'b0000);
    step("t4_err1",      0, 32'hF000_0000, IDLE,   3'b000, 3'b111, 1'b0, 1'b1, 32'h0,         3'b000, 4'b0000);
    step("t4_err2",      0, 32'hF000_0000, IDLE,   3'b111, 3'b000, 1'b1, 1'b1, 32'h0,         3'b000, 4'b0000);
    step("t4_okay",      0, 32'hF000_0000, IDLE,   3'b111, 3'b000, 1'b1, 1'b0, 32'h0,         3'b000, 4'b0000);
    step("t4_idle_dp",   0, 32'hF000_0000, NONSEQ, 3'b111, 3'b000, 1'b1, 1'b0, 32'h0,         3'b000, 4'b0000);
    step("t5_err1a",     0, 32'hF000_0004, NONSEQ, 3'b111, 3'b000, 1'b0, 1'b1, 32'h0,         3'b000, 4'b0000);
    step("t5_err2a",     0, 32'hF000_0004, NONSEQ, 3'b111, 3'b000, 1'b1, 1'b1, 32'h0,         3'b000, 4'b0000);
    step("t5_err1b",     1, 32'h8000_0000, IDLE,   3'b111, 3'b000, 1'b0, 1'b1, 32'h0,         3'b000, 4'b0000);
    step("t5_after_rst", 0, 32'h8000_0000, IDLE,   3'b111, 3'b000, 1'b1, 1'b0, 32'h0,         3'b000, 4'b0000);
    step("t6_s2_only",   0, 32'h6000_0000, IDLE,   3'b111, 3'b000, 1'b1, 1'b0, 32'h0,         3'b000, 4'b0100);
    step("t6_overlap",   0, 32'h4000_0000, IDLE,   3'b111, 3'b000, 1'b1, 1'b0, 32'h0,         3'b010, 4'b0010);
    step("t6_idle_hit",  0, 32'h8000_0000, IDLE,   3'b111, 3'b000, 1'b1, 1'b0, 32'hCAFE_0001, 3'b000, 4'b0000);
    step("rw_addr",      0, 32'h0000_0000, NONSEQ, 3'b111, 3'b000, 1'b1, 1'b0, 32'h0,         3'b001, 4'b0001);
    step("rw_wait_rst",  1, 32'h8000_0000, IDLE,   3'b110, 3'b000, 1'b0, 1'b0, 32'hCAFE_0000, 3'b000, 4'b0000);
    step("rw_after",     0, 32'h8000_0000, IDLE,   3'b110, 3'b000, 1'b1, 1'b0, 32'h0,         3'b000, 4'b0000);

    @(negedge HCLK);
    #1;
    check("queue_drained", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
